// File: rtl/train_sequencer.sv
// train_sequencer: run-sequence controller for one train.
//
// Steps through departure warning, acceleration, cruise, braking and door
// phases, and drives the state code plus the duration request consumed by an
// external countdown timer. Each timed phase runs three sub-phases:
//   CLR  - request 0 so the timer always sees the request change
//   LOAD - request the phase duration
//   WAIT - hold the duration; the phase ends on the edge sampling timer=1
//
// Ports:
//   clk, rst_n     system clock (rising edge), async active-low reset
//   start          departure request, honoured in IDLE only
//   stop_req       stop request, honoured in CRUISE only
//   emergency      emergency stop, highest priority
//   door_clear     doorway unobstructed, sampled at DOOR_CLOSE expiry
//   timer          countdown done flag from the timer (1 = expired)
//   t              19-bit duration request to the timer
//   present_state  current state code (also fed to the timer)
//   motor, brake, door_open, busy   registered actuator/status outputs
//
// state      | meaning
// -----------+---------------------------------------------
// IDLE    0  | parked, doors open, brake applied
// WARN    1  | departure warning (T_WARN)
// ACCEL   2  | traction on, accelerating (T_ACCEL)
// CRUISE  3  | traction on, waiting for stop_req
// BRAKE   4  | braking (T_BRAKE)
// DOOR_OPEN 5| doors open dwell (T_DOOR)
// DOOR_CLOSE 6| doors closing dwell (T_DOOR), checks door_clear
// EMERG   7  | emergency stop, held while emergency=1
// RECOVER 8  | post-emergency hold (T_RECOVER)
// 9..15      | unused, return to IDLE

module train_sequencer #(
  parameter logic [18:0] T_WARN    = 19'd8,
  parameter logic [18:0] T_ACCEL   = 19'd16,
  parameter logic [18:0] T_BRAKE   = 19'd16,
  parameter logic [18:0] T_DOOR    = 19'd32,
  parameter logic [18:0] T_RECOVER = 19'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop_req,
  input  logic        emergency,
  input  logic        door_clear,
  input  logic        timer,
  output logic [18:0] t,
  output logic [3:0]  present_state,
  output logic        motor,
  output logic        brake,
  output logic        door_open,
  output logic        busy
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WARN       = 4'd1,
    ST_ACCEL      = 4'd2,
    ST_CRUISE     = 4'd3,
    ST_BRAKE      = 4'd4,
    ST_DOOR_OPEN  = 4'd5,
    ST_DOOR_CLOSE = 4'd6,
    ST_EMERG      = 4'd7,
    ST_RECOVER    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    SUB_CLR  = 2'd0,
    SUB_LOAD = 2'd1,
    SUB_WAIT = 2'd2
  } sub_e;

  // A zero duration would never produce a request change; clamp to 1.
  localparam logic [18:0] D_WARN    = (T_WARN    == 19'd0) ? 19'd1 : T_WARN;
  localparam logic [18:0] D_ACCEL   = (T_ACCEL   == 19'd0) ? 19'd1 : T_ACCEL;
  localparam logic [18:0] D_BRAKE   = (T_BRAKE   == 19'd0) ? 19'd1 : T_BRAKE;
  localparam logic [18:0] D_DOOR    = (T_DOOR    == 19'd0) ? 19'd1 : T_DOOR;
  localparam logic [18:0] D_RECOVER = (T_RECOVER == 19'd0) ? 19'd1 : T_RECOVER;

  state_e      state_q, state_d;
  sub_e        sub_q, sub_d;
  state_e      succ;
  logic [18:0] t_q, t_d;
  logic        motor_q, motor_d;
  logic        brake_q, brake_d;
  logic        door_open_q, door_open_d;
  logic        busy_q, busy_d;

  function automatic logic [18:0] dur_of(input state_e s);
    logic [18:0] d;
    d = 19'd0;
    case (s)
      ST_WARN:       d = D_WARN;
      ST_ACCEL:      d = D_ACCEL;
      ST_BRAKE:      d = D_BRAKE;
      ST_DOOR_OPEN:  d = D_DOOR;
      ST_DOOR_CLOSE: d = D_DOOR;
      ST_RECOVER:    d = D_RECOVER;
      default:       d = 19'd0;
    endcase
    return d;
  endfunction

  // Successor of each timed state once its WAIT sub-phase sees expiry.
  always_comb begin
    succ = ST_IDLE;
    case (state_q)
      ST_WARN:       succ = ST_ACCEL;
      ST_ACCEL:      succ = ST_CRUISE;
      ST_BRAKE:      succ = ST_DOOR_OPEN;
      ST_DOOR_OPEN:  succ = ST_DOOR_CLOSE;
      ST_DOOR_CLOSE: succ = door_clear ? ST_IDLE : ST_DOOR_OPEN;
      default:       succ = ST_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !emergency) begin
          state_d = ST_WARN;
          sub_d   = SUB_CLR;
        end
      end
      ST_EMERG: begin
        if (!emergency) begin
          state_d = ST_RECOVER;
          sub_d   = SUB_CLR;
        end
      end
      ST_CRUISE: begin
        if (emergency) begin
          state_d = ST_EMERG;
          sub_d   = SUB_CLR;
        end else if (stop_req) begin
          state_d = ST_BRAKE;
          sub_d   = SUB_CLR;
        end
      end
      ST_WARN, ST_ACCEL, ST_BRAKE, ST_DOOR_OPEN, ST_DOOR_CLOSE, ST_RECOVER: begin
        if (emergency) begin
          state_d = ST_EMERG;
          sub_d   = SUB_CLR;
        end else begin
          case (sub_q)
            SUB_CLR:  sub_d = SUB_LOAD;
            SUB_LOAD: sub_d = SUB_WAIT;
            SUB_WAIT: begin
              // Expiry during CLR/LOAD belongs to the previous request.
              if (timer) begin
                state_d = succ;
                sub_d   = SUB_CLR;
              end
            end
            default:  sub_d = SUB_CLR;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        sub_d   = SUB_CLR;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered and
  // change on the same edge as present_state.
  always_comb begin
    t_d         = 19'd0;
    motor_d     = 1'b0;
    brake_d     = 1'b0;
    door_open_d = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    if (sub_d != SUB_CLR) begin
      t_d = dur_of(state_d);
    end
    case (state_d)
      ST_IDLE:      begin brake_d = 1'b1; door_open_d = 1'b1; end
      ST_ACCEL:     motor_d = 1'b1;
      ST_CRUISE:    motor_d = 1'b1;
      ST_BRAKE:     brake_d = 1'b1;
      ST_DOOR_OPEN: door_open_d = 1'b1;
      ST_EMERG:     brake_d = 1'b1;
      ST_RECOVER:   brake_d = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sub_q       <= SUB_CLR;
      t_q         <= 19'd0;
      motor_q     <= 1'b0;
      brake_q     <= 1'b1;
      door_open_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      t_q         <= t_d;
      motor_q     <= motor_d;
      brake_q     <= brake_d;
      door_open_q <= door_open_d;
      busy_q      <= busy_d;
    end
  end

  assign t             = t_q;
  assign present_state = state_q;
  assign motor         = motor_q;
  assign brake         = brake_q;
  assign door_open     = door_open_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Testbench for train_sequencer: ideal countdown timer, phase/age model of
// the sequencer checked every cycle, plus directed dwell-length checks.
module tb_train_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, stop_req, emergency, door_clear;
  logic        timer;
  logic [18:0] t;
  logic [3:0]  present_state;
  logic        motor, brake, door_open, busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  bit stuck  = 0;
  int ts[$];

  train_sequencer #(
    .T_WARN(19'd3), .T_ACCEL(19'd4), .T_BRAKE(19'd2),
    .T_DOOR(19'd5), .T_RECOVER(19'd8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req),
    .emergency(emergency), .door_clear(door_clear), .timer(timer),
    .t(t), .present_state(present_state), .motor(motor), .brake(brake),
    .door_open(door_open), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Ideal countdown timer: reloads on a change to a nonzero request,
  // reports done while its count is zero.
  logic [18:0] cnt, t_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 0;
      t_prev <= 0;
    end else begin
      if (t != t_prev && t != 0) cnt <= t;
      else if (cnt != 0)         cnt <= cnt - 1;
      t_prev <= t;
    end
  end
  assign timer = stuck ? 1'b1 : (cnt == 0);

  // Behavioural model: current phase and cycles spent in it.
  function automatic int dur(input int s);
    case (s)
      1: return 3;
      2: return 4;
      4: return 2;
      5: return 5;
      6: return 5;
      8: return 8;
      default: return 0;
    endcase
  endfunction

  int m_state, m_age, ns;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_age   <= 0;
    end else begin
      ns = m_state;
      if (m_state == 0) begin
        if (start && !emergency) ns = 1;
      end else if (m_state == 7) begin
        if (!emergency) ns = 8;
      end else if (emergency) begin
        ns = 7;
      end else if (m_state == 3) begin
        if (stop_req) ns = 4;
      end else if (dur(m_state) != 0) begin
        if (m_age >= 2 && timer) begin
          case (m_state)
            1: ns = 2;
            2: ns = 3;
            4: ns = 5;
            5: ns = 6;
            6: ns = door_clear ? 0 : 5;
            default: ns = 0;
          endcase
        end
      end else begin
        ns = 0;
      end
      m_state <= ns;
      m_age   <= (ns != m_state) ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_state", present_state, m_state);
      check("m_t", t, (dur(m_state) != 0 && m_age >= 1) ? dur(m_state) : 0);
      check("m_motor", motor, (m_state == 2 || m_state == 3));
      check("m_brake", brake, (m_state == 0 || m_state == 4 || m_state == 7 || m_state == 8));
      check("m_door", door_open, (m_state == 0 || m_state == 5));
      check("m_busy", busy, (m_state != 0));
    end
  end

  task automatic measure(input logic [3:0] code, input int exp_len, input string name);
    int n;
    n = 0;
    ts.delete();
    while (present_state == code && n < 200) begin
      ts.push_back(int'(t));
      n++;
      @(negedge clk);
    end
    check(name, n, exp_len);
  endtask

  task automatic wait_for(input logic [3:0] code, input string name);
    int n;
    n = 0;
    while (present_state != code && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(name, present_state, code);
  endtask

  task automatic depart();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    rst_n = 1; start = 0; stop_req = 0; emergency = 0; door_clear = 1;
    #3 rst_n = 0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_state", present_state, 0);
    check("rst_t", t, 0);
    check("rst_brake", brake, 1);
    check("rst_door", door_open, 1);
    check("rst_busy", busy, 0);

    // emergency beats start in IDLE
    start = 1; emergency = 1;
    repeat (3) @(negedge clk);
    check("prio_idle", present_state, 0);
    start = 0; emergency = 0;

    // departure path, stop_req ignored in WARN
    depart();
    stop_req = 1;
    check("start_lat", present_state, 1);
    measure(1, 6, "warn_len");
    if (ts.size() >= 6) begin
      check("warn_t0", ts[0], 0);
      check("warn_t1", ts[1], 3);
      check("warn_t5", ts[5], 3);
    end
    stop_req = 0;
    measure(2, 7, "accel_len");
    check("cruise_entry", present_state, 3);
    repeat (3) @(negedge clk);
    check("cruise_hold", present_state, 3);
    check("cruise_motor", motor, 1);
    check("cruise_t", t, 0);

    // stop and doors
    door_clear = 1;
    stop_req = 1;
    @(negedge clk);
    stop_req = 0;
    check("stop_lat", present_state, 4);
    measure(4, 5, "brake_len");
    check("door_open_out", door_open, 1);
    measure(5, 8, "door_open_len");
    measure(6, 8, "door_close_len");
    check("back_idle", present_state, 0);

    // obstruction
    depart();
    wait_for(3, "obs_cruise");
    stop_req = 1;
    @(negedge clk);
    stop_req = 0;
    door_clear = 0;
    wait_for(6, "obs_close");
    measure(6, 8, "obs_close_len");
    check("obs_reopen", present_state, 5);
    check("obs_t0", t, 0);
    @(negedge clk);
    check("obs_t1", t, 5);
    door_clear = 1;
    wait_for(0, "obs_idle");

    // emergency during ACCEL WAIT
    depart();
    wait_for(2, "em_accel");
    repeat (2) @(negedge clk);
    emergency = 1;
    @(negedge clk);
    check("em_state", present_state, 7);
    check("em_t", t, 0);
    check("em_brake", brake, 1);
    check("em_motor", motor, 0);
    repeat (4) @(negedge clk);
    emergency = 0;
    @(negedge clk);
    measure(8, 11, "recover_len");
    check("recover_idle", present_state, 0);

    // emergency in WARN, then again during RECOVER
    depart();
    emergency = 1;
    @(negedge clk);
    check("em_warn", present_state, 7);
    emergency = 0;
    @(negedge clk);
    check("em_rec", present_state, 8);
    repeat (4) @(negedge clk);
    emergency = 1;
    @(negedge clk);
    check("rec_reemerg", present_state, 7);
    emergency = 0;
    wait_for(0, "rec_idle");

    // timer stuck at 1: every timed state lasts 3 cycles
    stuck = 1;
    depart();
    measure(1, 3, "stuck_warn");
    measure(2, 3, "stuck_accel");
    check("stuck_cruise", present_state, 3);
    stop_req = 1;
    @(negedge clk);
    stop_req = 0;
    door_clear = 1;
    measure(4, 3, "stuck_brake");
    measure(5, 3, "stuck_dopen");
    measure(6, 3, "stuck_dclose");
    check("stuck_idle", present_state, 0);
    stuck = 0;

    // reset mid-ACCEL
    depart();
    wait_for(2, "rst_accel");
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_state", present_state, 0);
    check("arst_t", t, 0);
    check("arst_brake", brake, 1);
    check("arst_motor", motor, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("arst_stay_idle", present_state, 0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
